// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline (master) and pipe_hazard_ctrl (slave).
// Optional perf counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REGIDX = 5
);
    logic [REGIDX-1:0] ifid_rs1;
    logic [REGIDX-1:0] ifid_rs2;
    logic              ifid_use_rs1;
    logic              ifid_use_rs2;
    logic [REGIDX-1:0] idex_rd;
    logic              idex_regwrite;
    logic [1:0]        idex_wbsel;
    logic              ex_redirect;
    logic              dmem_req;
    logic              dmem_ready;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_en;
    logic              idex_flush;
    logic              exmem_en;
    logic              memwb_en;
    logic              mem_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]       perf_stall;
    logic [31:0]       perf_flush;
    logic [31:0]       perf_memto;
`endif

    modport master (
        output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
        output idex_rd, idex_regwrite, idex_wbsel,
        output ex_redirect, dmem_req, dmem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        input  exmem_en, memwb_en, mem_err
`ifdef HAZ_PERF_CNT_EN
        , input perf_stall, perf_flush, perf_memto
`endif
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
        input  idex_rd, idex_regwrite, idex_wbsel,
        input  ex_redirect, dmem_req, dmem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        output exmem_en, memwb_en, mem_err
`ifdef HAZ_PERF_CNT_EN
        , output perf_stall, perf_flush, perf_memto
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32 pipeline: load-use bubbles, redirect squash,
// dmem-wait freeze with watchdog. Define HAZ_PERF_CNT_EN to add the 32-bit perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REGIDX          = 5,
    parameter logic [1:0]  WBSEL_MEM       = 2'b01,
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT     = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int unsigned LU_W = 2;
    localparam int unsigned WD_W = 8;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [LU_W-1:0] lu_cnt, lu_nxt;
    logic [WD_W-1:0] wd_cnt, wd_nxt;

    logic load_hz, mem_wait, wd_expire, lu_pend;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, mem_err;

    assign load_hz = hz.idex_regwrite && (hz.idex_wbsel == WBSEL_MEM)
                  && (hz.idex_rd != REGIDX'(0))
                  && ((hz.ifid_use_rs1 && (hz.ifid_rs1 == hz.idex_rd))
                   || (hz.ifid_use_rs2 && (hz.ifid_rs2 == hz.idex_rd)));
    assign mem_wait  = hz.dmem_req && !hz.dmem_ready;
    assign wd_expire = mem_wait && (wd_cnt == WD_W'(MEM_TIMEOUT - 1));
    // A stall interrupted by a freeze keeps its remaining count and resumes afterwards.
    assign lu_pend   = (state != ST_RUN) && (lu_cnt != '0);

    // Priority: freeze > watchdog release > redirect > load-use > normal.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        mem_err    = 1'b0;
        state_nxt  = state;
        lu_nxt     = lu_cnt;
        wd_nxt     = '0;
        if (rst) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            state_nxt = ST_RUN;
            lu_nxt    = '0;
        end else if (mem_wait && !wd_expire) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            state_nxt = ST_MEM_WAIT;
            wd_nxt    = wd_cnt + WD_W'(1);
        end else if (mem_wait) begin
            mem_err   = 1'b1;
            state_nxt = lu_pend ? ST_LU_STALL : ST_RUN;
        end else if (hz.ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            lu_nxt     = '0;
            state_nxt  = ST_RUN;
        end else if (lu_pend) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            lu_nxt     = lu_cnt - LU_W'(1);
            state_nxt  = (lu_cnt == LU_W'(1)) ? ST_RUN : ST_LU_STALL;
        end else if (load_hz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
                lu_nxt    = LU_W'(LU_STALL_CYCLES - 1);
                state_nxt = ST_LU_STALL;
            end else begin
                state_nxt = ST_RUN;
            end
        end else begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            lu_cnt <= '0;
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lu_cnt <= lu_nxt;
            wd_cnt <= wd_nxt;
        end
    end

    assign hz.pc_en      = pc_en;
    assign hz.ifid_en    = ifid_en;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_en    = idex_en;
    assign hz.idex_flush = idex_flush;
    assign hz.exmem_en   = exmem_en;
    assign hz.memwb_en   = memwb_en;
    assign hz.mem_err    = mem_err;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall, perf_flush, perf_memto;

    // Redirect cycles are the only ones that flush IF/ID, so ifid_flush marks them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_memto <= '0;
        end else begin
            if (!pc_en)     perf_stall <= perf_stall + 32'd1;
            if (ifid_flush) perf_flush <= perf_flush + 32'd1;
            if (mem_err)    perf_memto <= perf_memto + 32'd1;
        end
    end

    assign hz.perf_stall = perf_stall;
    assign hz.perf_flush = perf_flush;
    assign hz.perf_memto = perf_memto;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (LU_STALL_CYCLES=1 and 2) share stimulus.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REGIDX(5)) bus_a ();
    pipe_hazard_ctrl_if #(.REGIDX(5)) bus_b ();

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(16)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (bus_a.slave)
    );

    pipe_hazard_ctrl #(.LU_STALL_CYCLES(2), .MEM_TIMEOUT(16)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (bus_b.slave)
    );

    assign bus_b.ifid_rs1      = bus_a.ifid_rs1;
    assign bus_b.ifid_rs2      = bus_a.ifid_rs2;
    assign bus_b.ifid_use_rs1  = bus_a.ifid_use_rs1;
    assign bus_b.ifid_use_rs2  = bus_a.ifid_use_rs2;
    assign bus_b.idex_rd       = bus_a.idex_rd;
    assign bus_b.idex_regwrite = bus_a.idex_regwrite;
    assign bus_b.idex_wbsel    = bus_a.idex_wbsel;
    assign bus_b.ex_redirect   = bus_a.ex_redirect;
    assign bus_b.dmem_req      = bus_a.dmem_req;
    assign bus_b.dmem_ready    = bus_a.dmem_ready;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, mem_err}
    localparam logic [7:0] V_RST   = 8'b0000_0000;
    localparam logic [7:0] V_NORM  = 8'b1101_0110;
    localparam logic [7:0] V_STALL = 8'b0001_1110;
    localparam logic [7:0] V_REDIR = 8'b1111_1110;
    localparam logic [7:0] V_FRZ   = 8'b0000_0000;
    localparam logic [7:0] V_MERR  = 8'b1101_0111;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

`ifdef HAZ_PERF_CNT_EN
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;
    int unsigned exp_memto = 0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctl_a();
        return {bus_a.pc_en, bus_a.ifid_en, bus_a.ifid_flush, bus_a.idex_en,
                bus_a.idex_flush, bus_a.exmem_en, bus_a.memwb_en, bus_a.mem_err};
    endfunction

    function automatic logic [7:0] ctl_b();
        return {bus_b.pc_en, bus_b.ifid_en, bus_b.ifid_flush, bus_b.idex_en,
                bus_b.idex_flush, bus_b.exmem_en, bus_b.memwb_en, bus_b.mem_err};
    endfunction

    task automatic drive(input logic rw, input logic [1:0] wb, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic redir, input logic req, input logic rdy);
        bus_a.idex_regwrite = rw;
        bus_a.idex_wbsel    = wb;
        bus_a.idex_rd       = rd;
        bus_a.ifid_rs1      = rs1;
        bus_a.ifid_use_rs1  = u1;
        bus_a.ifid_rs2      = rs2;
        bus_a.ifid_use_rs2  = u2;
        bus_a.ex_redirect   = redir;
        bus_a.dmem_req      = req;
        bus_a.dmem_ready    = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push the expected controls for this cycle, then pop and compare mid-cycle.
    task automatic cyc(input string tag, input logic [7:0] ea, input logic [7:0] eb);
        logic [15:0] e;
        string       t;
        exp_q.push_back({ea, eb});
        tag_q.push_back(tag);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq({t, "_a"}, 32'(ctl_a()), 32'(e[15:8]));
            check_eq({t, "_b"}, 32'(ctl_b()), 32'(e[7:0]));
`ifdef HAZ_PERF_CNT_EN
            if (!rst) begin
                check_eq({t, "_pstall"}, bus_a.perf_stall, exp_stall);
                check_eq({t, "_pflush"}, bus_a.perf_flush, exp_flush);
                check_eq({t, "_pmemto"}, bus_a.perf_memto, exp_memto);
            end
            if (rst) begin
                exp_stall = 0;
                exp_flush = 0;
                exp_memto = 0;
            end else begin
                if (!e[15]) exp_stall++;
                if (e[13])  exp_flush++;
                if (e[8])   exp_memto++;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hazard_rs2_x5();
        drive(1'b1, 2'b01, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cyc("reset0", V_RST, V_RST);
        cyc("reset1", V_RST, V_RST);
        rst = 1'b0;
        cyc("run", V_NORM, V_NORM);

        // Load-use on rs2: one bubble for A, two for B.
        hazard_rs2_x5();
        cyc("lu_start", V_STALL, V_STALL);
        idle();
        cyc("lu_2nd", V_NORM, V_STALL);
        cyc("lu_done", V_NORM, V_NORM);

        // Non-hazards: rd=0, rs2 unused, ALU writeback.
        drive(1'b1, 2'b01, 5'd0, 5'd3, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("rd_zero", V_NORM, V_NORM);
        drive(1'b1, 2'b01, 5'd5, 5'd3, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("no_use_rs2", V_NORM, V_NORM);
        drive(1'b1, 2'b00, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("alu_wb", V_NORM, V_NORM);
        drive(1'b1, 2'b01, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs1", V_STALL, V_STALL);
        idle();
        cyc("lu_rs1_2nd", V_NORM, V_STALL);

        // Redirect during the second bubble of a two-cycle stall.
        hazard_rs2_x5();
        cyc("lu_pre_redir", V_STALL, V_STALL);
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("redir_in_lu", V_REDIR, V_REDIR);
        idle();
        cyc("after_redir", V_NORM, V_NORM);

        // Freeze masks a redirect; the flush lands on the ready cycle.
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("frz_redir", V_FRZ, V_FRZ);
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("ready_redir", V_REDIR, V_REDIR);
        idle();
        cyc("after_frz", V_NORM, V_NORM);

        // Freeze in the middle of B's stall: B resumes its last bubble afterwards.
        hazard_rs2_x5();
        cyc("lu_pre_frz", V_STALL, V_STALL);
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("frz_in_lu", V_FRZ, V_FRZ);
        idle();
        cyc("lu_resume", V_NORM, V_STALL);
        cyc("lu_resume_done", V_NORM, V_NORM);

        // Watchdog: 15 freeze cycles then a forced release.
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) cyc("wd_frz", V_FRZ, V_FRZ);
        cyc("wd_expire", V_MERR, V_MERR);
        cyc("wd_rearm", V_FRZ, V_FRZ);
        idle();
        cyc("wd_idle", V_NORM, V_NORM);

        // Reset in the middle of a freeze clears the watchdog count.
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc("pre_rst_frz", V_FRZ, V_FRZ);
        rst = 1'b1;
        cyc("rst_frz0", V_RST, V_RST);
        cyc("rst_frz1", V_RST, V_RST);
        rst = 1'b0;
        idle();
        cyc("post_rst", V_NORM, V_NORM);
        drive(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) cyc("wd2_frz", V_FRZ, V_FRZ);
        cyc("wd2_expire", V_MERR, V_MERR);
        idle();
        cyc("end_idle", V_NORM, V_NORM);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
